mul_scheduler: RTL
==================

# mul_scheduler

Shared-multiplier scheduler: round-robin arbitration of NREQ requesters onto one pipelined 4x4 unsigned multiplier, pushing tagged products into the downstream write FIFO. Sits between requester logic and the FIFO write port (Winc_o/Wdata_o/Wfull_i), in the Wclk domain. Stalls the pipeline on FIFO full without losing or duplicating products.

## Interface
- NREQ, 4: number of requesters (2..8).
- LAT, 2: multiplier register stages, grant edge to output valid (1..4).
- IDW, $clog2(NREQ): tag width, derived; not overridden.

- Wclk  in  1  clock, rising edge.
- Wrst_n  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-requester request level.
- a_i  in  NREQ x 4  per-requester operand a.
- b_i  in  NREQ x 4  per-requester operand b.
- gnt_o  out  NREQ  one-hot grant, combinational from state and req_i.
- Wfull_i  in  1  downstream FIFO full.
- Winc_o  out  1  FIFO write strobe.
- Wdata_o  out  IDW+8  {tag, product}, registered.
- busy_o  out  1  any pipeline stage valid.

## Operation
- Pointer ptr (IDW bits) marks highest-priority requester; reset 0.
- stall = out_valid & Wfull_i. issue = |req_i & ~stall.
- On issue: winner = first k with req_i[k], searching ptr, ptr+1, ... mod NREQ; gnt_o[winner]=1, others 0.
- At the edge with gnt_o[k]=1: a_i[k], b_i[k], tag k captured into stage 1; ptr <= (k+1) mod NREQ.
- Requester holds req_i and operands stable until it sees gnt_o[k] at an edge; keeping req_i high requests again next cycle.
- No issue: gnt_o all 0, ptr unchanged, stage 1 loads a bubble (valid=0) unless stalled.
- Product: unsigned a*b, full 8 bits, no truncation (max 15*15=225).
- Pipeline: LAT stages of {valid, tag, a/b or partial/final product}; last stage drives Wdata_o and out_valid.
- Winc_o = out_valid & ~Wfull_i.
- stall: every stage holds, no grant, Wdata_o stable.
- Bubbles are not squeezed out; stall only when last stage valid.
- Output order equals grant order.
- FIFO empty-side flow is out of scope; Wfull_i is the only back-pressure.

## Timing
- Reset (async assert, sync-release handled upstream): all valid bits 0, ptr 0, Wdata_o 0, Winc_o 0, gnt_o 0, busy_o 0, immediately on Wrst_n low.
- Reset mid-operation: in-flight products discarded; none emitted after release.
- Latency: grant at edge E0 -> Winc_o high during cycle after edge E0+LAT-1 (LAT=2: cycle after E1), consumed at E(LAT).
- Throughput: one product per cycle with Wfull_i low.
- Wfull_i rising while out_valid: Winc_o drops same cycle, gnt_o drops same cycle.
- Wfull_i falling: Winc_o and issue resume same cycle.
- Wfull_i high with out_valid=0: not a stall; pipeline keeps filling until a valid result reaches the last stage.
- Simultaneous requests: exactly one grant per cycle; pointer rotation guarantees each active requester a grant within NREQ issue cycles.
- ptr wrap: NREQ-1 -> 0.
- busy_o combinational OR of stage valids.

## Structure
- Package mul_sched_pkg: OPW=4, PW=8, stage record typedef {valid, tag, product}, default NREQ.
- Sub-module mul_pipe (LAT, IDW): operand/tag capture, multiply, stage registers, hold enable; scheduler top holds arbiter, ptr, stall/Winc logic.

## Test plan
- req_i=0001, a=3, b=5, Wfull_i=0 -> gnt_o=0001 one cycle; Winc_o high 2 cycles after grant edge, Wdata_o={0,8'd15}.
- req_i=1111 held, ptr=0, distinct operands -> grants 0,1,2,3,0,... on consecutive cycles; outputs in same order with tags 0..3.
- a=15,b=15 on req 2 -> Wdata_o={2,8'd225}; a=0,b=9 -> product 0.
- Result at output, Wfull_i high 3 cycles -> Winc_o 0, gnt_o 0, Wdata_o stable 3 cycles; on release each product written exactly once, order preserved.
- Persistent req_i[1] and req_i[3] only -> grants alternate 1,3,1,3.
- Wrst_n low with 2 products in flight -> Winc_o, busy_o, Wdata_o 0 immediately; no write after release; first new grant goes to lowest requester from ptr=0.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
// Operands are 4-bit unsigned, products are a full 8 bits.
package mul_sched_pkg;

    localparam int OPW      = 4;
    localparam int PW       = 8;
    localparam int TAGW     = 3;
    localparam int NREQ_DEF = 4;

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic [PW-1:0]   prod;
    } stage_t;

    function automatic logic [PW-1:0] umul(
        input logic [OPW-1:0] a,
        input logic [OPW-1:0] b
    );
        return PW'(a) * PW'(b);
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Multiplier pipeline: product formed at capture, then carried with its
// tag through LAT holdable stages; the last stage is the visible output.
module mul_pipe
    import mul_sched_pkg::*;
#(
    parameter int LAT = 2,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           vld_i,
    input  logic [IDW-1:0] tag_i,
    input  logic [OPW-1:0] a_i,
    input  logic [OPW-1:0] b_i,
    output stage_t         out_o,
    output logic           busy_o
);

    stage_t stage_q [LAT];
    stage_t stage_d [LAT];

    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d[0].valid = vld_i;
            stage_d[0].tag   = TAGW'(tag_i);
            stage_d[0].prod  = umul(a_i, b_i);
            for (int i = 1; i < LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy_o = busy_o | stage_q[i].valid;
        end
    end

    assign out_o = stage_q[LAT-1];

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin arbiter feeding one shared pipelined multiplier and
// pushing {tag, product} into the write FIFO, stalling on Wfull_i.
module mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int LAT  = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      Wclk,
    input  logic                      Wrst_n,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ-1:0][OPW-1:0]  a_i,
    input  logic [NREQ-1:0][OPW-1:0]  b_i,
    output logic [NREQ-1:0]           gnt_o,
    input  logic                      Wfull_i,
    output logic                      Winc_o,
    output logic [IDW+PW-1:0]         Wdata_o,
    output logic                      busy_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    logic           stall;
    logic           issue;
    stage_t         out_st;
    logic           unused_tag;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grants are masked during reset so gnt_o clears immediately.
    assign stall = out_st.valid & Wfull_i;
    assign issue = found & ~stall & Wrst_n;

    always_comb begin
        gnt_o = '0;
        if (issue) begin
            gnt_o[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = IDW'((int'(win) + 1) % NREQ);
        end
    end

    always_ff @(posedge Wclk or negedge Wrst_n) begin
        if (!Wrst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    mul_pipe #(
        .LAT (LAT),
        .IDW (IDW)
    ) u_pipe (
        .clk    (Wclk),
        .rst_n  (Wrst_n),
        .en_i   (~stall),
        .vld_i  (issue),
        .tag_i  (win),
        .a_i    (a_i[win]),
        .b_i    (b_i[win]),
        .out_o  (out_st),
        .busy_o (busy_o)
    );

    assign Winc_o     = out_st.valid & ~Wfull_i;
    assign Wdata_o    = {out_st.tag[IDW-1:0], out_st.prod};
    assign unused_tag = ^out_st.tag;

endmodule
